multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style sequencer that drives the existing DataPath as a multi-cycle MIPS-subset core.
- Replaces the single-cycle Controler.
- Steps each instruction through fetch/decode/execute/memory/writeback states, issuing per-state mux selects, write enables and ALUOP.
- Holds in memory states until a ready handshake arrives, counts retired instructions, and halts on an illegal encoding.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OPcode  in  6  IR[31:26] from datapath
- funct  in  6  IR[5:0] from datapath
- ALUZero  in  1  ALU zero flag
- mem_ready  in  1  memory ack, one-cycle pulse completing current access
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load (includes taken branch)
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2
- ALUOP  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- SgnZero  out  1  1 = sign-extend imm, 0 = zero-extend
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write strobe
- instr_done  out  1  one-cycle pulse on retire
- instr_count  out  CNT_W  retired instructions, wraps
- halted  out  1  high in HALT

Behaviour:
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000 (sign-extended)
  - andi 001100 (zero-extended)
  - j 000010
- R-type funct → ALUOP: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct is illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP, HALT. Encoded in 4 bits.
- Reset (reset=0), asynchronous:
  - state = FETCH, instr_count = 0.
  - All strobes (MemWrite, IRWrite, PCWrite, RegWrite, mem_req, instr_done) forced 0 while reset is low.
  - All selects = 0.
- Outputs are decoded from state only, except PCWrite/IRWrite in FETCH (gated by mem_ready) and PCWrite in BEQ (gated by ALUZero). Unlisted outputs in any state = 0.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=ADD, PCSource=00.
  - While mem_ready=0: stay, IRWrite=PCWrite=0.
  - When mem_ready=1: IRWrite=PCWrite=1, go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOP=ADD, SgnZero=1 (precompute branch target).
  - Dispatch on OPcode: lw/sw → MEMADR; R-type with legal funct → REX; addi/andi → IEX; beq → BEQ; j → JMP; else → HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD, SgnZero=1. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, IorD=1. Wait for mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Retire, → FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1 held until mem_ready. On mem_ready, retire, → FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOP from funct. → RWB.
- RWB: RegWrite=1, RegDst=1. Retire, → FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10. ALUOP ADD (addi) or AND (andi). SgnZero 1 (addi) or 0 (andi). → IWB.
- IWB: RegWrite=1, RegDst=0. Retire, → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=ALUZero. Retire, → FETCH.
- JMP: PCSource=10, PCWrite=1. Retire, → FETCH.
- HALT: terminal; only reset exits. halted=1, no strobes.
- Retire:
  - instr_done=1 in the retiring cycle.
  - instr_count increments on the following edge; wraps at 2^CNT_W−1 → 0.
- Latency with mem_ready tied high: R/addi/andi/sw 4 cycles, lw 5, beq/j 3.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction aborts immediately with no further strobes.

Decomposition:
- Shared package:
  - opcode and funct constants
  - ALUOP encodings
  - ALUSrcB/PCSource encodings
  - state enum
- One sub-module: alu_decoder. Combinational funct → {ALUOP, legal}.

Test Plan:
- mem_ready=1, add (OPcode 000000, funct 100000) → states FETCH, DECODE, REX, RWB; RegWrite=1, RegDst=1 in cycle 4; instr_count 0→1.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEMRD → IRWrite is a single pulse in the ready cycle; MemtoReg=1, RegWrite=1 in MEMWB; 10 cycles total.
- beq with ALUZero=1 → PCWrite=1, PCSource=01 in BEQ; with ALUZero=0 → PCWrite=0; both retire after 3 cycles.
- andi → SgnZero=0, ALUOP=010 in IEX; addi → SgnZero=1, ALUOP=000.
- OPcode 111111, or R-type funct 000111 → HALT, halted=1, all strobes stay 0 for 20 cycles; reset pulse → FETCH, instr_count=0.
- CNT_W=4, 16 j instructions → instr_count wraps to 0; reset asserted during MEMWR → MemWrite drops in the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct codes,
// ALU/mux select values, the sequencer state enum and the registered control word.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b100
  } aluop_e;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StRex, StRwb, StIex, StIwb, StBeq, StJmp, StHalt
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    aluop_e     aluop;
    logic       sgn_zero;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CtrlFetch = '{
    mem_req: 1'b1, iord: 1'b0, mem_write: 1'b0, pc_write: 1'b0, pc_source: PcAlu,
    alu_src_a: 1'b0, alu_src_b: SrcBFour, aluop: AluAdd, sgn_zero: 1'b0, reg_dst: 1'b0,
    mem_to_reg: 1'b0, reg_write: 1'b0, instr_done: 1'b0, halted: 1'b0
  };

  // State-only part of the control word; mem_ready/ALUZero gating is applied in the top.
  function automatic ctrl_t ctrl_decode(state_e st, logic [5:0] op, aluop_e rop);
    ctrl_t c;
    c = '0;
    unique case (st)
      StFetch:  c = CtrlFetch;
      StDecode: begin c.alu_src_b = SrcBImmSh; c.sgn_zero = 1'b1; end
      StMemAdr: begin c.alu_src_a = 1'b1; c.alu_src_b = SrcBImm; c.sgn_zero = 1'b1; end
      StMemRd:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      StMemWb:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      StMemWr:  begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
      StRex:    begin c.alu_src_a = 1'b1; c.alu_src_b = SrcBRt; c.aluop = rop; end
      StRwb:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      StIex: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.aluop     = (op == OpAndi) ? AluAnd : AluAdd;
        c.sgn_zero  = (op != OpAndi);
      end
      StIwb:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      StBeq: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SrcBRt;
        c.aluop      = AluSub;
        c.pc_source  = PcAluOut;
        c.instr_done = 1'b1;
      end
      StJmp:    begin c.pc_source = PcJump; c.pc_write = 1'b1; c.instr_done = 1'b1; end
      StHalt:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bus. master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [5:0]       OPcode;
  logic [5:0]       funct;
  logic             ALUZero;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSource;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOP;
  logic             SgnZero;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             halted;

  modport master (
    input  OPcode, funct, ALUZero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOP,
           SgnZero, RegDst, MemtoReg, RegWrite, instr_done, instr_count, halted
  );

  modport slave (
    output OPcode, funct, ALUZero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOP,
           SgnZero, RegDst, MemtoReg, RegWrite, instr_done, instr_count, halted
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation; flags unsupported funct codes as illegal.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output aluop_e     aluop,
  output logic       legal
);
  always_comb begin
    aluop = AluAdd;
    legal = 1'b1;
    case (funct)
      FnAdd:   aluop = AluAdd;
      FnSub:   aluop = AluSub;
      FnAnd:   aluop = AluAnd;
      FnOr:    aluop = AluOr;
      FnSlt:   aluop = AluSlt;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: registered Moore control word plus the few
// handshake-gated strobes (fetch load, branch taken, store completion).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl;
  logic [CNT_W-1:0] count_q;
  aluop_e           r_aluop;
  logic             r_legal;
  logic             retire;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .funct (bus.funct),
    .aluop (r_aluop),
    .legal (r_legal)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.OPcode)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRtype:        state_d = r_legal ? StRex : StHalt;
          OpAddi, OpAndi: state_d = StIex;
          OpBeq:          state_d = StBeq;
          OpJ:            state_d = StJmp;
          default:        state_d = StHalt;
        endcase
      end
      StMemAdr: state_d = (bus.OPcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StRex:    state_d = StRwb;
      StIex:    state_d = StIwb;
      StMemWb, StRwb, StIwb, StBeq, StJmp: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;
    endcase
  end

  // Control word is registered from the next state, so it always matches state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      ctrl_q  <= CtrlFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d, bus.OPcode, r_aluop);
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // Everything is forced quiet while reset is held, including the FETCH selects.
  assign ctrl   = reset ? ctrl_q : '0;
  assign retire = ctrl.instr_done | (reset & (state_q == StMemWr) & bus.mem_ready);

  assign bus.mem_req     = ctrl.mem_req;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = reset & (state_q == StFetch) & bus.mem_ready;
  assign bus.PCWrite     = ctrl.pc_write |
                           (reset & (state_q == StFetch) & bus.mem_ready) |
                           (reset & (state_q == StBeq) & bus.ALUZero);
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOP       = ctrl.aluop;
  assign bus.SgnZero     = ctrl.sgn_zero;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.instr_done  = retire;
  assign bus.instr_count = count_q;
  assign bus.halted      = ctrl.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of single instructions checked through a
// scoreboard queue, plus hand-written handshake, halt, wrap and reset-abort sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(4)) bus ();

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         cycles;
    logic [2:0] aluop3;
    logic       sgn3;
    logic       rw;
    logic       rd;
    logic       mtr;
    logic       mw;
    logic       pcw;
    logic [1:0] pcs;
  } vec_t;

  vec_t       vecs[11];
  vec_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_count = 4'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic reset_dut();
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #3;
    check("rst_mem_req", int'(bus.mem_req), 0);
    check("rst_count", int'(bus.instr_count), 0);
    reset = 1'b1;
    exp_count = 4'd0;
    @(negedge clk);
    check("post_rst_mem_req", int'(bus.mem_req), 1);
    check("post_rst_alusrcb", int'(bus.ALUSrcB), 1);
    check("post_rst_halted", int'(bus.halted), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    logic done;
    logic [2:0] al3;
    logic sg3, rw, rd, mtr, mw, pcw;
    logic [1:0] pcs;
    vec_t e;
    sb_q.push_back(v);
    bus.OPcode = v.op; bus.funct = v.fn; bus.ALUZero = v.zero; bus.mem_ready = 1'b1;
    n = 0; done = 1'b0;
    al3 = '0; sg3 = 0; rw = 0; rd = 0; mtr = 0; mw = 0; pcw = 0; pcs = '0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 3) begin al3 = bus.ALUOP; sg3 = bus.SgnZero; end
      if (bus.instr_done) begin
        done = 1'b1;
        rw = bus.RegWrite; rd = bus.RegDst; mtr = bus.MemtoReg; mw = bus.MemWrite;
        pcw = bus.PCWrite; pcs = bus.PCSource;
      end
      @(posedge clk); #1;
    end
    e = sb_q.pop_front();
    check({e.name, "_retired"}, int'(done), 1);
    if (done) begin
      exp_count = exp_count + 4'd1;
      check({e.name, "_cycles"}, n, e.cycles);
      check({e.name, "_aluop"}, int'(al3), int'(e.aluop3));
      check({e.name, "_sgnzero"}, int'(sg3), int'(e.sgn3));
      check({e.name, "_regwrite"}, int'(rw), int'(e.rw));
      check({e.name, "_regdst"}, int'(rd), int'(e.rd));
      check({e.name, "_memtoreg"}, int'(mtr), int'(e.mtr));
      check({e.name, "_memwrite"}, int'(mw), int'(e.mw));
      check({e.name, "_pcwrite"}, int'(pcw), int'(e.pcw));
      check({e.name, "_pcsource"}, int'(pcs), int'(e.pcs));
      check({e.name, "_count"}, int'(bus.instr_count), int'(exp_count));
    end
  endtask

  task automatic halt_seq(input string name, input logic [5:0] op, input logic [5:0] fn);
    int bad;
    bus.OPcode = op; bus.funct = fn; bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!bus.halted || bus.mem_req || bus.MemWrite || bus.IRWrite || bus.PCWrite ||
          bus.RegWrite || bus.instr_done) bad++;
      @(posedge clk); #1;
    end
    check({name, "_quiet"}, bad, 0);
    check({name, "_count"}, int'(bus.instr_count), int'(exp_count));
  endtask

  initial begin
    int n, irw_pulses, irw_cycle;
    logic done, rw, mtr;
    bus.OPcode = '0; bus.funct = '0; bus.ALUZero = 1'b0; bus.mem_ready = 1'b1;

    vecs[0]  = '{"add",    6'b000000, 6'b100000, 1'b0, 4, 3'b000, 1'b0, 1, 1, 0, 0, 0, 2'b00};
    vecs[1]  = '{"sub",    6'b000000, 6'b100010, 1'b0, 4, 3'b001, 1'b0, 1, 1, 0, 0, 0, 2'b00};
    vecs[2]  = '{"and",    6'b000000, 6'b100100, 1'b0, 4, 3'b010, 1'b0, 1, 1, 0, 0, 0, 2'b00};
    vecs[3]  = '{"or",     6'b000000, 6'b100101, 1'b0, 4, 3'b011, 1'b0, 1, 1, 0, 0, 0, 2'b00};
    vecs[4]  = '{"slt",    6'b000000, 6'b101010, 1'b0, 4, 3'b100, 1'b0, 1, 1, 0, 0, 0, 2'b00};
    vecs[5]  = '{"addi",   6'b001000, 6'b000000, 1'b0, 4, 3'b000, 1'b1, 1, 0, 0, 0, 0, 2'b00};
    vecs[6]  = '{"andi",   6'b001100, 6'b111111, 1'b0, 4, 3'b010, 1'b0, 1, 0, 0, 0, 0, 2'b00};
    vecs[7]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 5, 3'b000, 1'b1, 1, 0, 1, 0, 0, 2'b00};
    vecs[8]  = '{"sw",     6'b101011, 6'b000000, 1'b0, 4, 3'b000, 1'b1, 0, 0, 0, 1, 0, 2'b00};
    vecs[9]  = '{"beq_t",  6'b000100, 6'b000000, 1'b1, 3, 3'b001, 1'b0, 0, 0, 0, 0, 1, 2'b01};
    vecs[10] = '{"j",      6'b000010, 6'b000000, 1'b0, 3, 3'b000, 1'b0, 0, 0, 0, 0, 1, 2'b10};

    // Reset held with mem_ready high: strobes and selects stay low.
    @(posedge clk); #1;
    check("rst_irwrite", int'(bus.IRWrite), 0);
    check("rst_pcwrite", int'(bus.PCWrite), 0);
    check("rst_alusrcb", int'(bus.ALUSrcB), 0);
    reset_dut();

    foreach (vecs[i]) run_vec(vecs[i]);
    begin
      vec_t v;
      v = vecs[9]; v.name = "beq_nt"; v.zero = 1'b0; v.pcw = 1'b0;
      run_vec(v);
    end

    // lw with ready held off 3 cycles in FETCH and 2 in MEMRD.
    bus.OPcode = OpLwC(); bus.funct = '0;
    n = 0; done = 0; irw_pulses = 0; irw_cycle = 0; rw = 0; mtr = 0;
    while (!done && n < 20) begin
      bus.mem_ready = !((n + 1) <= 3 || (n + 1) == 7 || (n + 1) == 8);
      @(negedge clk);
      n++;
      if (bus.IRWrite) begin irw_pulses++; irw_cycle = n; end
      if (n == 7) check("lw_memrd_iord", int'({bus.mem_req, bus.IorD}), 3);
      if (bus.instr_done) begin done = 1; rw = bus.RegWrite; mtr = bus.MemtoReg; end
      @(posedge clk); #1;
    end
    check("lwd_retired", int'(done), 1);
    check("lwd_cycles", n, 10);
    check("lwd_irwrite_pulses", irw_pulses, 1);
    check("lwd_irwrite_cycle", irw_cycle, 4);
    check("lwd_memwb", int'({rw, mtr}), 3);
    exp_count = exp_count + 4'd1;
    check("lwd_count", int'(bus.instr_count), int'(exp_count));

    // Counter wrap: 16 jumps from a fresh reset bring the 4-bit count back to 0.
    reset_dut();
    for (int i = 0; i < 16; i++) run_vec(vecs[10]);
    check("wrap_count_zero", int'(bus.instr_count), 0);

    halt_seq("halt_op", 6'b111111, 6'b000000);
    reset_dut();
    halt_seq("halt_fn", 6'b000000, 6'b000111);
    reset_dut();

    // sw stalled in MEMWR, then reset mid-cycle must drop the write immediately.
    bus.OPcode = 6'b101011; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("memwr_memwrite", int'(bus.MemWrite), 1);
    #2 reset = 1'b0;
    #1;
    check("abort_memwrite", int'(bus.MemWrite), 0);
    check("abort_mem_req", int'(bus.mem_req), 0);
    check("abort_count", int'(bus.instr_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_refetch", int'(bus.mem_req), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [5:0] OpLwC();
    return 6'b100011;
  endfunction

endmodule
